regfile_dump_ctrl: RTL and testbench

Synthesizable register-file snapshot controller for the pipelined RV32IMF core. On a trigger (explicit request, cycle budget, or pipeline quiescence) it freezes the pipeline and streams every register of every architectural register file (integer `rf`, float `rff`, …) out over a valid/ready port, one entry per beat, then signals completion. It replaces the fixed-delay, bench-only register dump with a parametrised, handshake-driven unit usable in simulation, on FPGA, or behind the AXI4 debug path.

---
 rtl/regfile_dump_ctrl.sv | 110 +++++++++++
 tb/tb_regfile_dump_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump_ctrl.sv
// regfile_dump_ctrl: freezes the pipeline and streams every register of every
// register file out over a valid/ready port, one entry per beat.
module regfile_dump_ctrl #(
    parameter int XLEN = 32,
    parameter int NREGS = 32,
    parameter int NFILES = 2,
    parameter int CYCLE_LIMIT = 0,
    parameter int IDLE_LIMIT = 16,
    localparam int FW = NFILES > 1 ? $clog2(NFILES) : 1,
    localparam int IW = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            wb_valid,
    output logic [FW-1:0]   rd_file,
    output logic [IW-1:0]   rd_addr,
    input  logic [XLEN-1:0] rd_data,
    output logic            freeze,
    output logic            dump_valid,
    input  logic            dump_ready,
    output logic [FW-1:0]   dump_file,
    output logic [IW-1:0]   dump_idx,
    output logic [XLEN-1:0] dump_data,
    output logic            dump_last,
    output logic            busy,
    output logic            done,
    output logic [31:0]     cycle_cnt
);
    localparam logic [FW-1:0] LAST_FILE = FW'(NFILES - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NREGS - 1);

    typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_t;

    state_t state, next;
    logic [31:0] idle_cnt;
    logic [FW-1:0] file_ptr;
    logic [IW-1:0] idx_ptr;
    logic last_q, trig, hs;

    assign trig = start
        || (CYCLE_LIMIT != 0 && cycle_cnt == 32'(CYCLE_LIMIT - 1))
        || (IDLE_LIMIT != 0 && !wb_valid && idle_cnt == 32'(IDLE_LIMIT - 1));
    assign hs = dump_valid && dump_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            IDLE: next = trig ? READ : IDLE;
            READ: next = SEND;
            SEND: next = hs ? (dump_last ? DONE : READ) : SEND;
            DONE: next = start ? READ : DONE;
            default: next = IDLE;
        endcase
    end

    // freeze is decoded straight from the state so the hazard unit sees it in the same cycle
    always_comb begin
        freeze = state == READ || state == SEND;
        busy = freeze;
        dump_valid = state == SEND;
        done = state == DONE;
        dump_last = dump_valid && last_q;
        rd_file = file_ptr;
        rd_addr = idx_ptr;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_cnt <= '0;
            idle_cnt <= '0;
            file_ptr <= '0;
            idx_ptr <= '0;
            dump_file <= '0;
            dump_idx <= '0;
            dump_data <= '0;
            last_q <= 1'b0;
        end else begin
            if (state == IDLE) begin
                cycle_cnt <= cycle_cnt == '1 ? cycle_cnt : cycle_cnt + 32'd1;
                idle_cnt <= wb_valid ? '0 : idle_cnt + 32'd1;
                if (trig) begin
                    file_ptr <= '0;
                    idx_ptr <= '0;
                end
            end
            if (state == DONE && start) begin
                cycle_cnt <= '0;
                idle_cnt <= '0;
                file_ptr <= '0;
                idx_ptr <= '0;
            end
            if (state == READ) begin
                dump_data <= rd_data;
                dump_file <= file_ptr;
                dump_idx <= idx_ptr;
                last_q <= file_ptr == LAST_FILE && idx_ptr == LAST_IDX;
            end
            if (hs && !dump_last) begin
                idx_ptr <= idx_ptr == LAST_IDX ? '0 : idx_ptr + 1'b1;
                file_ptr <= idx_ptr == LAST_IDX ? file_ptr + 1'b1 : file_ptr;
            end
        end
    end
endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// tb_regfile_dump_ctrl: directed checks of cycle/idle/start triggers, backpressure,
// re-arm, mid-dump reset and a 3-file configuration.
module tb_regfile_dump_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
    logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
    logic wb = 1'b1;
    logic ready = 1'b1;
    int sel = 0;

    function automatic logic [31:0] model(input int f, input int a);
        return (f == 0 && a == 5) ? 32'hDEADBEEF : 32'h1000_0000 * 32'(f + 1) + 32'h0101 * 32'(a);
    endfunction

    // instance a: cycle trigger after 10 idle cycles
    logic [0:0] rf_a, df_a;
    logic [4:0] ra_a, di_a;
    logic [31:0] rd_a, dd_a, cnt_a;
    logic fz_a, dv_a, dl_a, bz_a, dn_a;
    assign rd_a = model(int'(rf_a), int'(ra_a));
    regfile_dump_ctrl #(.XLEN(32), .NREGS(32), .NFILES(2), .CYCLE_LIMIT(10), .IDLE_LIMIT(0)) u_a (
        .clk(clk), .reset(rst_a), .start(start_a), .wb_valid(wb),
        .rd_file(rf_a), .rd_addr(ra_a), .rd_data(rd_a), .freeze(fz_a),
        .dump_valid(dv_a), .dump_ready(ready), .dump_file(df_a), .dump_idx(di_a),
        .dump_data(dd_a), .dump_last(dl_a), .busy(bz_a), .done(dn_a), .cycle_cnt(cnt_a));

    // instance b: idle trigger after 16 quiet cycles
    logic [0:0] rf_b, df_b;
    logic [4:0] ra_b, di_b;
    logic [31:0] rd_b, dd_b, cnt_b;
    logic fz_b, dv_b, dl_b, bz_b, dn_b;
    assign rd_b = model(int'(rf_b), int'(ra_b));
    regfile_dump_ctrl #(.XLEN(32), .NREGS(32), .NFILES(2), .CYCLE_LIMIT(0), .IDLE_LIMIT(16)) u_b (
        .clk(clk), .reset(rst_b), .start(start_b), .wb_valid(wb),
        .rd_file(rf_b), .rd_addr(ra_b), .rd_data(rd_b), .freeze(fz_b),
        .dump_valid(dv_b), .dump_ready(ready), .dump_file(df_b), .dump_idx(di_b),
        .dump_data(dd_b), .dump_last(dl_b), .busy(bz_b), .done(dn_b), .cycle_cnt(cnt_b));

    // instance c: 3 files of 8 registers, start-only
    logic [1:0] rf_c, df_c;
    logic [2:0] ra_c, di_c;
    logic [31:0] rd_c, dd_c, cnt_c;
    logic fz_c, dv_c, dl_c, bz_c, dn_c;
    assign rd_c = model(int'(rf_c), int'(ra_c));
    regfile_dump_ctrl #(.XLEN(32), .NREGS(8), .NFILES(3), .CYCLE_LIMIT(0), .IDLE_LIMIT(0)) u_c (
        .clk(clk), .reset(rst_c), .start(start_c), .wb_valid(wb),
        .rd_file(rf_c), .rd_addr(ra_c), .rd_data(rd_c), .freeze(fz_c),
        .dump_valid(dv_c), .dump_ready(ready), .dump_file(df_c), .dump_idx(di_c),
        .dump_data(dd_c), .dump_last(dl_c), .busy(bz_c), .done(dn_c), .cycle_cnt(cnt_c));

    logic v_valid, v_last, v_done, v_freeze, v_busy;
    logic [7:0] v_file, v_idx;
    logic [31:0] v_data;
    assign v_valid = sel == 0 ? dv_a : sel == 1 ? dv_b : dv_c;
    assign v_last = sel == 0 ? dl_a : sel == 1 ? dl_b : dl_c;
    assign v_done = sel == 0 ? dn_a : sel == 1 ? dn_b : dn_c;
    assign v_freeze = sel == 0 ? fz_a : sel == 1 ? fz_b : fz_c;
    assign v_busy = sel == 0 ? bz_a : sel == 1 ? bz_b : bz_c;
    assign v_file = sel == 0 ? 8'(df_a) : sel == 1 ? 8'(df_b) : 8'(df_c);
    assign v_idx = sel == 0 ? 8'(di_a) : sel == 1 ? 8'(di_b) : 8'(di_c);
    assign v_data = sel == 0 ? dd_a : sel == 1 ? dd_b : dd_c;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at the negedge where freeze was first seen; runs until done or budget.
    task automatic run_dump(input int nr, input int nf, input bit bp);
        int e, cyc;
        logic stall;
        logic [7:0] pf, pi;
        logic [31:0] pd;
        e = 0;
        cyc = 0;
        stall = 1'b0;
        pf = '0;
        pi = '0;
        pd = '0;
        while (!v_done && cyc < 4000) begin
            if (stall) begin
                check("hold_valid", 32'(v_valid), 32'd1);
                check("hold_file", 32'(v_file), 32'(pf));
                check("hold_idx", 32'(v_idx), 32'(pi));
                check("hold_data", v_data, pd);
            end
            ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (v_valid && ready) begin
                check("beat_file", 32'(v_file), 32'(e / nr));
                check("beat_idx", 32'(v_idx), 32'(e % nr));
                check("beat_data", v_data, model(e / nr, e % nr));
                check("beat_last", 32'(v_last), 32'(e == nr * nf - 1));
                check("beat_busy", 32'(v_busy && v_freeze), 32'd1);
                e++;
            end
            stall = v_valid && !ready;
            pf = v_file;
            pi = v_idx;
            pd = v_data;
            @(negedge clk);
            cyc++;
        end
        ready = 1'b1;
        check("beats", 32'(e), 32'(nr * nf));
        check("done_set", 32'(v_done), 32'd1);
        check("freeze_off", 32'(v_freeze), 32'd0);
        if (!bp) check("dump_cycles", 32'(cyc), 32'(2 * nr * nf));
    endtask

    initial begin
        int k, n, g, trig;
        repeat (2) @(negedge clk);
        check("rst_freeze", 32'(fz_a), 32'd0);
        check("rst_valid", 32'(dv_a), 32'd0);
        check("rst_busy", 32'(bz_a), 32'd0);
        check("rst_done", 32'(dn_a), 32'd0);
        check("rst_last", 32'(dl_a), 32'd0);
        check("rst_cnt", cnt_a, 32'd0);
        check("rst_addr", 32'(ra_a), 32'd0);
        check("rst_data", dd_a, 32'd0);

        // cycle trigger
        sel = 0;
        rst_a = 1'b0;
        k = 0;
        while (!fz_a && k < 50) begin
            @(negedge clk);
            k++;
            if (k == 5) check("cnt_mid", cnt_a, 32'd5);
        end
        check("cyc_trig", 32'(k), 32'd10);
        check("cnt_at_trig", cnt_a, 32'd10);
        check("trig_addr", 32'(ra_a), 32'd0);
        run_dump(32, 2, 1'b0);
        repeat (5) @(negedge clk);
        check("oneshot_freeze", 32'(fz_a), 32'd0);
        check("oneshot_done", 32'(dn_a), 32'd1);

        // re-arm with random backpressure
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        check("rearm_done", 32'(dn_a), 32'd0);
        check("rearm_freeze", 32'(fz_a), 32'd1);
        check("rearm_cnt", cnt_a, 32'd0);
        run_dump(32, 2, 1'b1);

        // reset in the middle of beat 20
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        n = 0;
        g = 0;
        while (n < 20 && g < 200) begin
            if (dv_a) n++;
            @(negedge clk);
            g++;
        end
        @(negedge clk);
        check("mid_idx", 32'(di_a), 32'd20);
        #2 rst_a = 1'b1;
        #1;
        check("arst_valid", 32'(dv_a), 32'd0);
        check("arst_freeze", 32'(fz_a), 32'd0);
        check("arst_busy", 32'(bz_a), 32'd0);
        check("arst_done", 32'(dn_a), 32'd0);
        check("arst_data", dd_a, 32'd0);
        @(negedge clk);
        rst_a = 1'b0;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        check("restart_freeze", 32'(fz_a), 32'd1);
        check("restart_addr", 32'(ra_a), 32'd0);
        run_dump(32, 2, 1'b0);

        // idle trigger
        sel = 1;
        rst_b = 1'b0;
        trig = -1;
        for (int i = 0; i < 60; i++) begin
            wb = (i < 5) || (i == 12);
            @(negedge clk);
            if (fz_b) begin
                trig = i;
                break;
            end
        end
        check("idle_trig", 32'(trig), 32'd28);
        wb = 1'b1;
        run_dump(32, 2, 1'b0);

        // 3 files x 8 regs; start held high through the dump must be ignored
        sel = 2;
        rst_c = 1'b0;
        @(negedge clk);
        check("c_idle_freeze", 32'(fz_c), 32'd0);
        start_c = 1'b1;
        @(negedge clk);
        check("c_freeze", 32'(fz_c), 32'd1);
        run_dump(8, 3, 1'b0);
        start_c = 1'b0;
        @(negedge clk);
        check("c_done_hold", 32'(dn_c), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
